// File: rtl/interboard_tx_scheduler_if.sv
// Bus bundle between the upper-layer sources, the tx scheduler and the interboard link.
// master = scheduler side, slave = sources plus the remote receiver.
interface interboard_tx_scheduler_if;
  logic       src0_valid;
  logic [2:0] src0_msg_type;
  logic [4:0] src0_number;
  logic       src1_valid;
  logic [2:0] src1_msg_type;
  logic [4:0] src1_number;
  logic [1:0] src_grant;
  logic       Ack_in;
  logic       Request_out;
  logic [5:0] inter_data_out;
  logic       busy;
  logic       tx_done;
  logic       tx_timeout;

  modport master (
    input  src0_valid, src0_msg_type, src0_number,
    input  src1_valid, src1_msg_type, src1_number,
    input  Ack_in,
    output src_grant, Request_out, inter_data_out, busy, tx_done, tx_timeout
  );

  modport slave (
    output src0_valid, src0_msg_type, src0_number,
    output src1_valid, src1_msg_type, src1_number,
    output Ack_in,
    input  src_grant, Request_out, inter_data_out, busy, tx_done, tx_timeout
  );
endinterface

// File: rtl/interboard_tx_scheduler.sv
// Round-robin picks one of two message sources and ships it to the other board as
// two 6-bit words over a Request/Ack handshake, with ack timeout and reset abort.
module interboard_tx_scheduler #(
  parameter int unsigned GAP_LEN = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        interboard_rst,
  interboard_tx_scheduler_if.master   bus
);
  localparam int unsigned CNT_MAX = (TIMEOUT > GAP_LEN) ? TIMEOUT : GAP_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned WORD_W  = 6;
  localparam int unsigned NUM_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ1, S_HOLD1, S_GAP, S_REQ2, S_HOLD2, S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last;
  logic [NUM_W-1:0]   r_number;
  logic               r_req;
  logic [WORD_W-1:0]  r_data;
  logic               r_busy;
  logic               r_done;
  logic               r_timeout;

  logic               w_rst;
  logic               w_both;
  logic               w_pick1;
  logic               w_grant_ok;
  logic [2:0]         w_win_type;
  logic [NUM_W-1:0]   w_win_number;
  logic               w_wait_state;
  logic               w_ack_event;
  logic               w_wait_expired;
  logic               w_abort;
  logic               w_gap_end;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_rst        = rst | interboard_rst;
  assign w_both       = bus.src0_valid & bus.src1_valid;
  // On a tie the source not granted last wins.
  assign w_pick1      = w_both ? ~r_last : bus.src1_valid;
  assign w_grant_ok   = (r_state == S_IDLE) && (bus.src0_valid || bus.src1_valid) && !w_rst;
  assign w_win_type   = w_pick1 ? bus.src1_msg_type : bus.src0_msg_type;
  assign w_win_number = w_pick1 ? bus.src1_number   : bus.src0_number;

  assign w_wait_state   = r_state inside {S_REQ1, S_HOLD1, S_REQ2, S_HOLD2};
  assign w_ack_event    = (((r_state == S_REQ1) || (r_state == S_REQ2)) && bus.Ack_in) ||
                          (((r_state == S_HOLD1) || (r_state == S_HOLD2)) && !bus.Ack_in);
  assign w_wait_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
  // An ack edge seen in the last allowed cycle still counts as on time.
  assign w_abort        = w_wait_state && !w_ack_event && w_wait_expired;
  assign w_gap_end      = (r_cnt == CNT_W'(GAP_LEN - 1));
  assign w_cnt_inc      = r_cnt + CNT_W'(1);

  assign bus.src_grant      = w_grant_ok ? {w_pick1, ~w_pick1} : 2'b00;
  assign bus.Request_out    = r_req;
  assign bus.inter_data_out = r_data;
  assign bus.busy           = r_busy;
  assign bus.tx_done        = r_done;
  assign bus.tx_timeout     = r_timeout;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_number  <= '0;
      r_req     <= 1'b0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      if (w_abort) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_number  <= '0;
        r_req     <= 1'b0;
        r_data    <= '0;
        r_busy    <= 1'b0;
        r_timeout <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_grant_ok) begin
              r_state  <= S_REQ1;
              r_last   <= w_pick1;
              r_number <= w_win_number;
              r_data   <= {3'b000, w_win_type};
              r_req    <= 1'b1;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
            end
          end
          S_REQ1: begin
            if (bus.Ack_in) begin
              r_state <= S_HOLD1;
              r_req   <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_HOLD1: begin
            // Word 2 goes on the wires as soon as the word-1 ack drops.
            if (!bus.Ack_in) begin
              r_state <= S_GAP;
              r_data  <= {1'b0, r_number};
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_GAP: begin
            if (w_gap_end) begin
              r_state <= S_REQ2;
              r_req   <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_REQ2: begin
            if (bus.Ack_in) begin
              r_state <= S_HOLD2;
              r_req   <= 1'b0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_HOLD2: begin
            if (!bus.Ack_in) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_data   <= '0;
              r_number <= '0;
              r_cnt    <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end
          default: begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// Directed-plus-random bench for interboard_tx_scheduler; a transaction-level model
// of sources, arbitration pointer and remote receiver supplies every expectation.
module tb_interboard_tx_scheduler;
  localparam int unsigned GAP_LEN = 2;
  localparam int unsigned TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst;
  logic interboard_rst;

  interboard_tx_scheduler_if bus();

  interboard_tx_scheduler #(.GAP_LEN(GAP_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int         n_pass      = 0;
  int         n_total     = 0;
  int         n_done_seen = 0;
  bit         pv [2];
  logic [2:0] pt [2];
  logic [4:0] pn [2];
  int         last_src;
  logic [5:0] cur_w1;
  logic [5:0] cur_w2;

  always @(negedge clk) if (bus.tx_done === 1'b1) n_done_seen++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src();
    bus.src0_valid    = pv[0];
    bus.src0_msg_type = pt[0];
    bus.src0_number   = pn[0];
    bus.src1_valid    = pv[1];
    bus.src1_msg_type = pt[1];
    bus.src1_number   = pn[1];
  endtask

  task automatic pend(input int s, input logic [2:0] t, input logic [4:0] n);
    pv[s] = 1'b1;
    pt[s] = t;
    pn[s] = n;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_grant"},   32'(bus.src_grant), 32'(0));
    chk({tag, "_req"},     32'(bus.Request_out), 32'(0));
    chk({tag, "_data"},    32'(bus.inter_data_out), 32'(0));
    chk({tag, "_busy"},    32'(bus.busy), 32'(0));
    chk({tag, "_done"},    32'(bus.tx_done), 32'(0));
    chk({tag, "_timeout"}, 32'(bus.tx_timeout), 32'(0));
  endtask

  task automatic chk_no_rst_code(input string tag);
    chk({tag, "_rst_code"}, 32'({bus.Request_out, bus.inter_data_out} == 7'h7F), 32'(0));
  endtask

  // At an IDLE sample point: expect a grant, then retire or re-arm the winner.
  task automatic arb_step(input bit rearm);
    int w;
    drive_src();
    #1;
    if (pv[0] && pv[1]) w = (last_src == 0) ? 1 : 0;
    else                w = pv[1] ? 1 : 0;
    chk("src_grant", 32'(bus.src_grant), 32'(1 << w));
    last_src = w;
    cur_w1   = 6'(pt[w]);
    cur_w2   = 6'(pn[w]);
    tick();
    if (rearm) begin
      pt[w] = 3'($urandom);
      pn[w] = 5'($urandom);
    end else begin
      pv[w] = 1'b0;
    end
    drive_src();
  endtask

  // Receiver: ack k cycles after the request is seen, hold ack for len cycles.
  task automatic send_word(input logic [5:0] w, input int k, input int len, input string tag);
    chk({tag, "_grant_quiet"}, 32'(bus.src_grant), 32'(0));
    chk({tag, "_req_rise"},    32'(bus.Request_out), 32'(1));
    chk({tag, "_data"},        32'(bus.inter_data_out), 32'(w));
    chk({tag, "_busy"},        32'(bus.busy), 32'(1));
    for (int i = 0; i < k; i++) begin
      bus.Ack_in = 1'b0;
      tick();
      chk({tag, "_req_wait"},  32'(bus.Request_out), 32'(1));
      chk({tag, "_data_wait"}, 32'(bus.inter_data_out), 32'(w));
      chk_no_rst_code(tag);
    end
    bus.Ack_in = 1'b1;
    tick();
    chk({tag, "_req_drop"},  32'(bus.Request_out), 32'(0));
    chk({tag, "_data_hold"}, 32'(bus.inter_data_out), 32'(w));
    for (int i = 1; i < len; i++) begin
      tick();
      chk({tag, "_req_low"},   32'(bus.Request_out), 32'(0));
      chk({tag, "_data_hold"}, 32'(bus.inter_data_out), 32'(w));
      chk_no_rst_code(tag);
    end
    bus.Ack_in = 1'b0;
    tick();
  endtask

  task automatic gap_phase(input logic [5:0] w2);
    for (int unsigned i = 0; i < GAP_LEN; i++) begin
      chk("gap_req",  32'(bus.Request_out), 32'(0));
      chk("gap_data", 32'(bus.inter_data_out), 32'(w2));
      chk("gap_busy", 32'(bus.busy), 32'(1));
      tick();
    end
  endtask

  task automatic finish_done();
    chk("done_pulse", 32'(bus.tx_done), 32'(1));
    chk("done_busy",  32'(bus.busy), 32'(1));
    chk("done_req",   32'(bus.Request_out), 32'(0));
    tick();
    chk("done_end",      32'(bus.tx_done), 32'(0));
    chk("idle_busy",     32'(bus.busy), 32'(0));
    chk("idle_timeout",  32'(bus.tx_timeout), 32'(0));
  endtask

  task automatic full_xfer(input bit rearm, input int k1, input int l1, input int k2, input int l2);
    arb_step(rearm);
    send_word(cur_w1, k1, l1, "w1");
    gap_phase(cur_w2);
    send_word(cur_w2, k2, l2, "w2");
    finish_done();
  endtask

  initial begin
    int n;
    int done0;
    bit bad;

    rst = 1'b1;
    interboard_rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      pv[s] = 1'b0;
      pt[s] = 3'd0;
      pn[s] = 5'd0;
    end
    drive_src();
    bus.Ack_in = 1'b0;
    last_src = 1;

    tick();
    tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    tick();
    chk_idle_zero("post_reset");

    // Single send: type 5, number 17, 11-cycle acks.
    pend(0, 3'd5, 5'd17);
    full_xfer(1'b0, 2, 11, 3, 11);
    chk("single_busy_after", 32'(bus.busy), 32'(0));

    // Fresh reset, then both sources valid continuously for three transfers.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_src = 1;
    pend(0, 3'($urandom), 5'($urandom));
    pend(1, 3'($urandom), 5'($urandom));
    full_xfer(1'b1, 1, 2, 0, 3);
    full_xfer(1'b1, 0, 1, 2, 4);
    full_xfer(1'b0, 3, 2, 1, 1);

    // Random traffic; a losing source keeps its request pending.
    for (int it = 0; it < 8; it++) begin
      for (int s = 0; s < 2; s++)
        if (!pv[s] && ($urandom_range(0, 1) == 1)) pend(s, 3'($urandom), 5'($urandom));
      if (!pv[0] && !pv[1]) pend(0, 3'($urandom), 5'($urandom));
      full_xfer(1'b0, int'($urandom_range(0, 4)), int'($urandom_range(1, 11)),
                int'($urandom_range(0, 4)), int'($urandom_range(1, 11)));
    end
    for (int it = 0; it < 2; it++)
      if (pv[0] || pv[1]) full_xfer(1'b0, 1, 2, 1, 2);

    // Ack never arrives.
    done0 = n_done_seen;
    pend(0, 3'd1, 5'd9);
    arb_step(1'b0);
    n = 0;
    while (bus.Request_out === 1'b1 && n < int'(TIMEOUT) + 10) begin
      n++;
      tick();
    end
    chk("timeout_req_cycles", 32'(n), 32'(TIMEOUT));
    chk("timeout_pulse",      32'(bus.tx_timeout), 32'(1));
    chk("timeout_busy",       32'(bus.busy), 32'(0));
    chk("timeout_req",        32'(bus.Request_out), 32'(0));
    tick();
    chk("timeout_once",       32'(bus.tx_timeout), 32'(0));
    chk("timeout_no_regrant", 32'(bus.src_grant), 32'(0));
    chk("timeout_no_done",    32'(n_done_seen), 32'(done0));

    // Ack stuck high after the word-1 ack.
    pend(1, 3'd2, 5'd20);
    arb_step(1'b0);
    chk("stuck_req",  32'(bus.Request_out), 32'(1));
    chk("stuck_data", 32'(bus.inter_data_out), 32'(cur_w1));
    bus.Ack_in = 1'b1;
    tick();
    n = 0;
    bad = 1'b0;
    while (bus.busy === 1'b1 && n < int'(TIMEOUT) + 10) begin
      if (bus.inter_data_out !== cur_w1 || bus.Request_out !== 1'b0) bad = 1'b1;
      n++;
      tick();
    end
    chk("stuck_hold_cycles", 32'(n), 32'(TIMEOUT));
    chk("stuck_no_word2",    32'(bad), 32'(0));
    chk("stuck_timeout",     32'(bus.tx_timeout), 32'(1));
    bus.Ack_in = 1'b0;
    tick();
    chk("stuck_timeout_once", 32'(bus.tx_timeout), 32'(0));
    chk("stuck_no_done",      32'(n_done_seen), 32'(done0));

    // interboard_rst while in REQ2, after a src0 grant.
    pend(0, 3'($urandom), 5'($urandom));
    arb_step(1'b0);
    send_word(cur_w1, 1, 3, "ir_w1");
    gap_phase(cur_w2);
    chk("ir_in_req2", 32'(bus.Request_out), 32'(1));
    done0 = n_done_seen;
    interboard_rst = 1'b1;
    tick();
    interboard_rst = 1'b0;
    last_src = 1;
    chk_idle_zero("ibrst");
    tick();
    tick();
    chk("ibrst_no_done", 32'(n_done_seen), 32'(done0));
    pend(0, 3'($urandom), 5'($urandom));
    pend(1, 3'($urandom), 5'($urandom));
    full_xfer(1'b0, 1, 2, 1, 2);
    full_xfer(1'b0, 0, 1, 0, 1);

    // rst while in GAP, after a src0 grant.
    pend(0, 3'($urandom), 5'($urandom));
    arb_step(1'b0);
    send_word(cur_w1, 0, 2, "rg_w1");
    chk("rg_in_gap", 32'(bus.Request_out), 32'(0));
    done0 = n_done_seen;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_src = 1;
    chk_idle_zero("rst_gap");
    tick();
    tick();
    chk("rst_gap_no_done", 32'(n_done_seen), 32'(done0));
    pend(0, 3'($urandom), 5'($urandom));
    pend(1, 3'($urandom), 5'($urandom));
    full_xfer(1'b0, 2, 1, 1, 2);
    full_xfer(1'b0, 1, 1, 1, 1);

    // All-ones message must never alias the reset code on the link.
    pend(0, 3'd7, 5'd31);
    full_xfer(1'b0, 1, 4, 1, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
